// File: rtl/ltc2195_pkg.sv
// Shared definitions for the LTC2195 receiver alignment controller.
package ltc2195_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_CHECK_FR = 3'd2,
        ST_SLIP     = 3'd3,
        ST_CHECK_TP = 3'd4,
        ST_LOCKED   = 3'd5,
        ST_FAIL     = 3'd6
    } state_t;

    localparam logic [7:0]  FR_PATTERN_DEF = 8'b11110000;
    localparam logic [15:0] TP_WORD_DEF    = 16'b1011001011101001;

    // Error accumulator add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/ltc2195_align.sv
// Word-alignment and test-pattern check sequencer for the LTC2195 LVDS receiver.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start after reset
// SETTLE   | let the deserializer output settle after start/bitslip
// CHECK_FR | compare frame word against the expected pattern (1 cycle)
// SLIP     | issue one bitslip pulse to the ISERDES (1 cycle)
// CHECK_TP | count channel words that differ from the test pattern
// LOCKED   | aligned; watching for two consecutive frame errors
// FAIL     | alignment or pattern check failed; hold until start
module ltc2195_align
    import ltc2195_pkg::*;
#(
    parameter logic [7:0]  FR_PATTERN = FR_PATTERN_DEF,
    parameter logic [15:0] TP_WORD    = TP_WORD_DEF,
    parameter int          SETTLE     = 16,
    parameter int          MAX_SLIPS  = 8,
    parameter int          CHECK_LEN  = 256
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic        tp_mode_in,
    input  logic [7:0]  FR_in,
    input  logic [15:0] ADC0_in,
    input  logic [15:0] ADC1_in,
    output logic        bitslip_out,
    output logic        aligned_out,
    output logic        tp_ok_out,
    output logic        fail_out,
    output logic [3:0]  slip_count_out,
    output logic [15:0] err_count_out,
    output logic [2:0]  state_out
);

    localparam logic [15:0] SETTLE_LD = 16'(SETTLE - 1);
    localparam logic [15:0] CHECK_LD  = 16'(CHECK_LEN - 1);
    localparam logic [3:0]  SLIP_MAX  = 4'(MAX_SLIPS);

    state_t      r_state;
    logic [15:0] r_settle_cnt;
    logic [15:0] r_check_cnt;
    logic [3:0]  r_slip_count;
    logic [15:0] r_err_count;
    logic        r_tp_ok;
    logic        r_fail;
    logic        r_glitch;
    logic        r_bitslip;
    logic        r_aligned;

    state_t      w_state_nxt;
    logic [15:0] w_settle_nxt;
    logic [15:0] w_check_nxt;
    logic [3:0]  w_slip_nxt;
    logic [15:0] w_err_nxt;
    logic        w_tp_ok_nxt;
    logic        w_fail_nxt;
    logic        w_glitch_nxt;
    logic        w_fr_match;
    logic [1:0]  w_tp_errs;
    logic [15:0] w_err_sum;

    assign w_fr_match = (FR_in == FR_PATTERN);
    assign w_tp_errs  = {1'b0, ADC0_in != TP_WORD} + {1'b0, ADC1_in != TP_WORD};
    assign w_err_sum  = sat_add16(r_err_count, w_tp_errs);

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= ST_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next-state, down-counter and status decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        w_check_nxt  = r_check_cnt;
        w_slip_nxt   = r_slip_count;
        w_err_nxt    = r_err_count;
        w_tp_ok_nxt  = r_tp_ok;
        w_fail_nxt   = r_fail;
        w_glitch_nxt = 1'b0;
        if (start_in) begin
            w_state_nxt  = ST_SETTLE;
            w_settle_nxt = SETTLE_LD;
            w_slip_nxt   = '0;
            w_err_nxt    = '0;
            w_tp_ok_nxt  = 1'b0;
            w_fail_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_SETTLE: begin
                    if (r_settle_cnt == '0) w_state_nxt  = ST_CHECK_FR;
                    else                    w_settle_nxt = r_settle_cnt - 16'd1;
                end
                ST_CHECK_FR: begin
                    if (w_fr_match) begin
                        if (tp_mode_in) begin
                            w_state_nxt = ST_CHECK_TP;
                            w_check_nxt = CHECK_LD;
                            // A re-lock must judge the pattern on fresh data only.
                            w_err_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_LOCKED;
                        end
                    end else if (r_slip_count == SLIP_MAX) begin
                        w_state_nxt = ST_FAIL;
                        w_fail_nxt  = 1'b1;
                    end else begin
                        // Counted on entry so the count always equals pulses issued.
                        w_state_nxt = ST_SLIP;
                        w_slip_nxt  = r_slip_count + 4'd1;
                    end
                end
                ST_SLIP: begin
                    w_state_nxt  = ST_SETTLE;
                    w_settle_nxt = SETTLE_LD;
                end
                ST_CHECK_TP: begin
                    w_err_nxt = w_err_sum;
                    if (r_check_cnt == '0) begin
                        if (w_err_sum == '0) begin
                            w_state_nxt = ST_LOCKED;
                            w_tp_ok_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_FAIL;
                            w_fail_nxt  = 1'b1;
                        end
                    end else begin
                        w_check_nxt = r_check_cnt - 16'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!w_fr_match) begin
                        if (r_glitch) begin
                            w_state_nxt  = ST_SETTLE;
                            w_settle_nxt = SETTLE_LD;
                            w_slip_nxt   = '0;
                            w_tp_ok_nxt  = 1'b0;
                        end else begin
                            w_glitch_nxt = 1'b1;
                        end
                    end
                end
                ST_FAIL: ;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Counters and registered outputs; pulse/aligned follow the next state so they line up with state_out.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_settle_cnt <= '0;
            r_check_cnt  <= '0;
            r_slip_count <= '0;
            r_err_count  <= '0;
            r_tp_ok      <= 1'b0;
            r_fail       <= 1'b0;
            r_glitch     <= 1'b0;
            r_bitslip    <= 1'b0;
            r_aligned    <= 1'b0;
        end else begin
            r_settle_cnt <= w_settle_nxt;
            r_check_cnt  <= w_check_nxt;
            r_slip_count <= w_slip_nxt;
            r_err_count  <= w_err_nxt;
            r_tp_ok      <= w_tp_ok_nxt;
            r_fail       <= w_fail_nxt;
            r_glitch     <= w_glitch_nxt;
            r_bitslip    <= (w_state_nxt == ST_SLIP);
            r_aligned    <= (w_state_nxt == ST_LOCKED);
        end
    end

    assign bitslip_out    = r_bitslip;
    assign aligned_out    = r_aligned;
    assign tp_ok_out      = r_tp_ok;
    assign fail_out       = r_fail;
    assign slip_count_out = r_slip_count;
    assign err_count_out  = r_err_count;
    assign state_out      = r_state;

endmodule

// File: tb/tb_ltc2195_align.sv
// Bench for ltc2195_align: receiver model with bitslip rotation, pattern injection, scoreboard of expectations.
module tb_ltc2195_align;
    import ltc2195_pkg::*;

    localparam int SETTLE_C    = 16;
    localparam int MAX_SLIPS_C = 8;
    localparam int CHECK_LEN_C = 256;
    localparam int ROUND_C     = SETTLE_C + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tp_mode = 1'b0;
    logic [7:0]  fr_drv = FR_PATTERN_DEF;
    logic        fr_rot_mode = 1'b0;
    logic [7:0]  fr_in;
    logic [15:0] adc0 = TP_WORD_DEF;
    logic [15:0] adc1 = TP_WORD_DEF;
    logic        bitslip, aligned, tp_ok, fail;
    logic [3:0]  slip_cnt;
    logic [15:0] err_cnt;
    logic [2:0]  st;

    int cyc = 0;
    int slips_seen = 0;
    int n_pulses = 0;
    int consec = 0;
    int pulse_cyc[$];
    logic prev_bs = 1'b0;
    logic corrupt0 = 1'b0;
    logic corrupt1 = 1'b0;
    int tp_idx = 0;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < (k & 7); i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Receiver starts three slips away from alignment; each bitslip rotates by one bit.
    assign fr_in = fr_rot_mode ? rotl8(FR_PATTERN_DEF, 3 - slips_seen) : fr_drv;

    ltc2195_align dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .start_in       (start),
        .tp_mode_in     (tp_mode),
        .FR_in          (fr_in),
        .ADC0_in        (adc0),
        .ADC1_in        (adc1),
        .bitslip_out    (bitslip),
        .aligned_out    (aligned),
        .tp_ok_out      (tp_ok),
        .fail_out       (fail),
        .slip_count_out (slip_cnt),
        .err_count_out  (err_cnt),
        .state_out      (st)
    );

    always @(posedge clk) cyc = cyc + 1;

    // Bitslip monitor and ADC pattern source, evaluated mid-cycle.
    always @(negedge clk) begin
        if (bitslip) begin
            n_pulses++;
            pulse_cyc.push_back(cyc);
            slips_seen++;
            if (prev_bs) consec++;
        end
        prev_bs = bitslip;
        adc0 = (st == 3'd4 && corrupt0) ? ~TP_WORD_DEF : TP_WORD_DEF;
        adc1 = (st == 3'd4 && corrupt1 && tp_idx >= 10 && tp_idx <= 50 && (tp_idx % 10) == 0)
               ? ~TP_WORD_DEF : TP_WORD_DEF;
        tp_idx = (st == 3'd4) ? tp_idx + 1 : 0;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_obs(input int got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, got, e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        n_pulses = 0;
        consec = 0;
        slips_seen = 0;
        pulse_cyc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Cycle index (start cycle = 0) at which state_out first equals s; -1 on timeout.
    task automatic wait_state(input logic [2:0] s, input int max, output int n);
        int cur;
        bit found;
        cur = 1;
        n = -1;
        found = 0;
        for (int i = 0; i < max && !found; i++) begin
            if (st == s) begin
                n = cur;
                found = 1;
            end else begin
                step(1);
                cur++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int hold;

        // Reset state and idle after release.
        sb_push("rst_state", 0); sb_push("rst_aligned", 0); sb_push("rst_fail", 0);
        sb_push("rst_slip", 0);  sb_push("rst_err", 0);     sb_push("rst_bitslip", 0);
        sb_push("idle_after_release", 0);
        step(3);
        sb_obs(st); sb_obs(aligned); sb_obs(fail);
        sb_obs(slip_cnt); sb_obs(err_cnt); sb_obs(bitslip);
        rst_n = 1'b1;
        step(5);
        sb_obs(st);

        // Direct lock: frame already aligned.
        sb_push("lock_cycle", ROUND_C); sb_push("lock_aligned", 1);
        sb_push("lock_pulses", 0);      sb_push("lock_slips", 0);
        clear_mon();
        fr_drv = FR_PATTERN_DEF;
        pulse_start();
        wait_state(3'd5, 100, n);
        sb_obs(n); sb_obs(aligned); sb_obs(n_pulses); sb_obs(slip_cnt);

        // Receiver model three slips off.
        sb_push("rot_lock_cycle", ROUND_C * 4); sb_push("rot_pulses", 3);
        sb_push("rot_gap1", ROUND_C);           sb_push("rot_gap2", ROUND_C);
        sb_push("rot_slips", 3);                sb_push("rot_aligned", 1);
        fr_rot_mode = 1'b1;
        clear_mon();
        pulse_start();
        wait_state(3'd5, 200, n);
        sb_obs(n); sb_obs(n_pulses);
        sb_obs(pulse_cyc.size() > 1 ? pulse_cyc[1] - pulse_cyc[0] : -1);
        sb_obs(pulse_cyc.size() > 2 ? pulse_cyc[2] - pulse_cyc[1] : -1);
        sb_obs(slip_cnt); sb_obs(aligned);
        fr_rot_mode = 1'b0;

        // Frame never matches: exhaust slips then fail and hold.
        sb_push("fail_cycle", ROUND_C * (MAX_SLIPS_C + 1)); sb_push("fail_pulses", MAX_SLIPS_C);
        sb_push("fail_out", 1); sb_push("fail_slips", MAX_SLIPS_C); sb_push("fail_aligned", 0);
        sb_push("fail_hold_state", 6); sb_push("fail_hold_slips", MAX_SLIPS_C);
        fr_drv = 8'h00;
        clear_mon();
        pulse_start();
        wait_state(3'd6, 300, n);
        sb_obs(n); sb_obs(n_pulses); sb_obs(fail); sb_obs(slip_cnt); sb_obs(aligned);
        step(20);
        sb_obs(st); sb_obs(slip_cnt);

        // Test pattern with ADC1 corrupted on five cycles.
        sb_push("tp_bad_cycle", ROUND_C + CHECK_LEN_C); sb_push("tp_bad_err", 5);
        sb_push("tp_bad_fail", 1); sb_push("tp_bad_ok", 0); sb_push("tp_bad_hold_err", 5);
        fr_drv = FR_PATTERN_DEF;
        tp_mode = 1'b1;
        corrupt1 = 1'b1;
        clear_mon();
        pulse_start();
        wait_state(3'd6, 400, n);
        sb_obs(n); sb_obs(err_cnt); sb_obs(fail); sb_obs(tp_ok);
        step(10);
        sb_obs(err_cnt);
        corrupt1 = 1'b0;

        // Clean test pattern.
        sb_push("tp_ok_cycle", ROUND_C + CHECK_LEN_C); sb_push("tp_ok", 1);
        sb_push("tp_ok_err", 0); sb_push("tp_ok_fail", 0); sb_push("tp_ok_aligned", 1);
        pulse_start();
        wait_state(3'd5, 400, n);
        sb_obs(n); sb_obs(tp_ok); sb_obs(err_cnt); sb_obs(fail); sb_obs(aligned);

        // Single-cycle frame glitch is tolerated.
        sb_push("glitch1_aligned_cycles", 5); sb_push("glitch1_state", 5);
        fr_drv = 8'h00;
        step(1);
        fr_drv = FR_PATTERN_DEF;
        hold = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            hold += int'(aligned);
        end
        sb_obs(hold); sb_obs(st);

        // Two-cycle glitch drops lock and re-aligns.
        sb_push("glitch2_aligned", 0); sb_push("glitch2_state", 1);
        sb_push("glitch2_tp_ok", 0);   sb_push("glitch2_slips", 0);
        sb_push("relock_cycle", ROUND_C); sb_push("relock_aligned", 1);
        tp_mode = 1'b0;
        fr_drv = 8'h00;
        step(2);
        fr_drv = FR_PATTERN_DEF;
        sb_obs(aligned); sb_obs(st); sb_obs(tp_ok); sb_obs(slip_cnt);
        wait_state(3'd5, 100, n);
        sb_obs(n); sb_obs(aligned);

        // Asynchronous reset in the middle of a SLIP cycle.
        sb_push("slip_seen", 3);
        sb_push("arst_bitslip", 0); sb_push("arst_state", 0); sb_push("arst_slips", 0);
        sb_push("arst_aligned", 0); sb_push("arst_fail", 0); sb_push("arst_err", 0);
        sb_push("arst_hold_state", 0); sb_push("post_arst_idle", 0);
        fr_rot_mode = 1'b1;
        clear_mon();
        pulse_start();
        hold = 0;
        while (!bitslip && hold < 100) begin
            step(1);
            hold++;
        end
        sb_obs(st);
        rst_n = 1'b0;
        #1;
        sb_obs(bitslip); sb_obs(st); sb_obs(slip_cnt);
        sb_obs(aligned); sb_obs(fail); sb_obs(err_cnt);
        step(3);
        sb_obs(st);
        rst_n = 1'b1;
        step(5);
        sb_obs(st);
        fr_rot_mode = 1'b0;

        // Restart issued during CHECK_TP clears counters.
        sb_push("mid_tp_entry", ROUND_C); sb_push("mid_tp_err", 5);
        sb_push("restart_state", 1); sb_push("restart_err", 0);
        sb_push("restart_tp_ok", 0); sb_push("restart_fail", 0); sb_push("restart_slips", 0);
        fr_drv = FR_PATTERN_DEF;
        tp_mode = 1'b1;
        corrupt0 = 1'b1;
        pulse_start();
        wait_state(3'd4, 100, n);
        sb_obs(n);
        step(5);
        sb_obs(err_cnt);
        pulse_start();
        sb_obs(st); sb_obs(err_cnt); sb_obs(tp_ok); sb_obs(fail); sb_obs(slip_cnt);
        corrupt0 = 1'b0;

        check_val("bitslip_back_to_back", consec, 0);
        check_val("sb_leftover", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
